// File: rtl/laser_frame_player.sv
// laser_frame_player: double-buffered laser point playback engine with programmable per-point dwell.
//
// Ports:
//   clock_in, reset_in         system clock, asynchronous active-high reset
//   dwell_in                   cycles per point (values below 3 behave as 3), sampled once per point
//   wr_valid_in/wr_ready_out   point write stream handshake; ready drops while a frame waits to swap in
//   wr_point_in, wr_last_in    {x, y, colour} beat and end-of-frame marker
//   x_out, y_out, color_out    registered current point (colour forced to 0 while blanked)
//   point_strobe_out           one-cycle pulse whenever the point outputs update
//   frame_sync_out             one-cycle pulse coincident with the strobe of point 0
//   blank_out                  high until the first committed frame is played
//   overflow_out               sticky flag for beats dropped beyond DEPTH
module laser_frame_player #(
    parameter int COORD_W    = 16,
    parameter int COLOR_W    = 8,
    parameter int NUM_COLORS = 3,
    parameter int DEPTH      = 1024,
    parameter int POINT_W    = 2*COORD_W + NUM_COLORS*COLOR_W,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic [15:0]                   dwell_in,
    input  logic                          wr_valid_in,
    output logic                          wr_ready_out,
    input  logic [POINT_W-1:0]            wr_point_in,
    input  logic                          wr_last_in,
    output logic [COORD_W-1:0]            x_out,
    output logic [COORD_W-1:0]            y_out,
    output logic [NUM_COLORS*COLOR_W-1:0] color_out,
    output logic                          point_strobe_out,
    output logic                          frame_sync_out,
    output logic                          blank_out,
    output logic                          overflow_out
);

    localparam int CLR_W = NUM_COLORS*COLOR_W;
    localparam logic [ADDR_W:0] ONE_A   = 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DWELL = 2'd3;

    logic [POINT_W-1:0] bank0 [DEPTH];
    logic [POINT_W-1:0] bank1 [DEPTH];
    logic [POINT_W-1:0] rd_data_q;

    logic [1:0]         state_q, state_d;
    logic               sel_q, sel_d;
    logic               pend_q, pend_d;
    logic [ADDR_W:0]    wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]    new_len_q, new_len_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [ADDR_W:0]    rd_addr_q, rd_addr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        per_q, per_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [CLR_W-1:0]   color_q, color_d;
    logic               strobe_q, strobe_d;
    logic               sync_q, sync_d;
    logic               blank_q, blank_d;
    logic               ovf_q, ovf_d;

    logic wr_fire;
    logic wr_store;
    logic dwell_end;
    logic wrap;
    logic swap;

    // The top address bit set means wr_addr has reached DEPTH: the bank is full.
    assign wr_fire   = wr_valid_in && !pend_q;
    assign wr_store  = wr_fire && !wr_addr_q[ADDR_W];
    assign dwell_end = (state_q == ST_DWELL) && (cnt_q == per_q - 16'd1);
    assign wrap      = (rd_addr_q == len_q - ONE_A);
    // A pending frame is adopted straight away when idle, otherwise only at the
    // end of the last point's dwell so a frame is never torn.
    assign swap      = pend_q && ((state_q == ST_IDLE) || (dwell_end && wrap));

    // select = 0 reads bank0 and writes bank1; select = 1 the opposite.
    always_ff @(posedge clock_in) begin
        if (wr_store && sel_q)
            bank0[wr_addr_q[ADDR_W-1:0]] <= wr_point_in;
        if (wr_store && !sel_q)
            bank1[wr_addr_q[ADDR_W-1:0]] <= wr_point_in;
        rd_data_q <= sel_q ? bank1[rd_addr_q[ADDR_W-1:0]] : bank0[rd_addr_q[ADDR_W-1:0]];
    end

    always_comb begin
        sel_d     = swap ? !sel_q : sel_q;
        pend_d    = swap ? 1'b0 : ((wr_fire && wr_last_in) ? 1'b1 : pend_q);
        wr_addr_d = swap ? '0 : (wr_store ? wr_addr_q + ONE_A : wr_addr_q);
        // Frame length is min(beats stored including this one, DEPTH).
        new_len_d = (wr_fire && wr_last_in) ? (wr_addr_q[ADDR_W] ? DEPTH_A : wr_addr_q + ONE_A) : new_len_q;
        len_d     = swap ? new_len_q : len_q;
        ovf_d     = ovf_q || (wr_fire && wr_addr_q[ADDR_W]);
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        strobe_d  = 1'b0;
        sync_d    = 1'b0;
        blank_d   = blank_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d   = ST_FETCH;
                    rd_addr_d = '0;
                    cnt_d     = '0;
                end
            end
            ST_FETCH: begin
                per_d   = (dwell_in < 16'd3) ? 16'd3 : dwell_in;
                cnt_d   = cnt_q + 16'd1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                x_d      = rd_data_q[POINT_W-1 -: COORD_W];
                y_d      = rd_data_q[POINT_W-COORD_W-1 -: COORD_W];
                color_d  = rd_data_q[CLR_W-1:0];
                strobe_d = 1'b1;
                sync_d   = (rd_addr_q == '0);
                blank_d  = 1'b0;
                cnt_d    = cnt_q + 16'd1;
                state_d  = ST_DWELL;
            end
            default: begin
                // FETCH and LOAD occupy two cycles of the period, so DWELL ends
                // when the counter has reached D-1.
                if (dwell_end) begin
                    rd_addr_d = wrap ? '0 : rd_addr_q + ONE_A;
                    cnt_d     = '0;
                    state_d   = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            pend_q    <= 1'b0;
            wr_addr_q <= '0;
            new_len_q <= '0;
            len_q     <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            per_q     <= 16'd3;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= '0;
            strobe_q  <= 1'b0;
            sync_q    <= 1'b0;
            blank_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pend_q    <= pend_d;
            wr_addr_q <= wr_addr_d;
            new_len_q <= new_len_d;
            len_q     <= len_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
            strobe_q  <= strobe_d;
            sync_q    <= sync_d;
            blank_q   <= blank_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wr_ready_out     = !pend_q;
    assign x_out            = x_q;
    assign y_out            = y_q;
    assign color_out        = blank_q ? '0 : color_q;
    assign point_strobe_out = strobe_q;
    assign frame_sync_out   = sync_q;
    assign blank_out        = blank_q;
    assign overflow_out     = ovf_q;

endmodule
